// File: rtl/fixed_point_multiplier_seq_pkg.sv
// Shared arithmetic defines for the fixed-point multiplier: default widths and
// FSM encodings, numbered above the divider's states so the two never collide.
package fixed_point_multiplier_seq_pkg;

    localparam int MUL_WIDTH = 32;
    localparam int MUL_SCALE = 16;

    typedef enum logic [3:0] {
        MUL_IDLE    = 4'd8,
        MUL_ITERATE = 4'd9,
        MUL_FINISH  = 4'd10,
        MUL_DONE    = 4'd11
    } mul_state_t;

endpackage

// File: rtl/fixed_point_multiplier_seq_abs.sv
// fixed_point_abs: combinational two's-complement magnitude plus sign bit.
// The most negative input maps to 2^(WIDTH-1) as an unsigned magnitude.
module fixed_point_abs #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] mag,
    output logic             neg
);

    assign neg = value[WIDTH-1];
    assign mag = neg ? (~value + {{(WIDTH-1){1'b0}}, 1'b1}) : value;

endmodule

// File: rtl/fixed_point_multiplier_seq.sv
// Sequential signed Qm.n multiplier, C = (A * B) >> SCALE, one product bit per clock.
// FIXED_MUL_SATURATE_EN: clamp oResult on overflow instead of wrapping.
//
// state       | meaning
// MUL_IDLE    | waiting for iInputReady, latches operand magnitudes and sign
// MUL_ITERATE | WIDTH shift-add steps over the magnitudes
// MUL_FINISH  | scale, overflow check, apply sign, register oResult/oOverflow
// MUL_DONE    | oOutputReady high while the client holds iInputReady
module fixed_point_multiplier_seq
    import fixed_point_multiplier_seq_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH,
    parameter int SCALE = MUL_SCALE
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic             iInputReady,
    output logic [WIDTH-1:0] oResult,
    output logic             oOutputReady,
    output logic             oOverflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [2*WIDTH-1:0] NEG_LIMIT = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [2*WIDTH-1:0] POS_LIMIT = NEG_LIMIT - 1'b1;

    mul_state_t state, state_next;

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      counter;
    logic               sign;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               a_neg, b_neg;

    logic [2*WIDTH-1:0] mag_full;
    logic [WIDTH-1:0]   mag;
    logic               ovf;
    logic [WIDTH-1:0]   res_wrap;
    logic [WIDTH-1:0]   res;

    fixed_point_abs #(.WIDTH(WIDTH)) u_abs_a (.value(iA), .mag(a_mag), .neg(a_neg));
    fixed_point_abs #(.WIDTH(WIDTH)) u_abs_b (.value(iB), .mag(b_mag), .neg(b_neg));

    always_ff @(posedge Clock) begin
        if (Reset) state <= MUL_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            MUL_IDLE:    if (iInputReady) state_next = MUL_ITERATE;
            MUL_ITERATE: if (counter == LAST) state_next = MUL_FINISH;
            MUL_FINISH:  state_next = MUL_DONE;
            MUL_DONE:    if (!iInputReady) state_next = MUL_IDLE;
            default:     state_next = MUL_IDLE;
        endcase
    end

    // Magnitude is truncated before the sign is applied, so rounding is toward zero.
    always_comb begin
        mag_full = acc >> SCALE;
        mag      = mag_full[WIDTH-1:0];
        ovf      = sign ? (mag_full > NEG_LIMIT) : (mag_full > POS_LIMIT);
        res_wrap = sign ? (~mag + {{(WIDTH-1){1'b0}}, 1'b1}) : mag;
`ifdef FIXED_MUL_SATURATE_EN
        if (ovf)
            res = sign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        else
            res = res_wrap;
`else
        res = res_wrap;
`endif
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            mcand        <= '0;
            acc          <= '0;
            mplier       <= '0;
            counter      <= '0;
            sign         <= 1'b0;
            oResult      <= '0;
            oOverflow    <= 1'b0;
            oOutputReady <= 1'b0;
        end else begin
            case (state)
                MUL_IDLE: begin
                    oOutputReady <= 1'b0;
                    if (iInputReady) begin
                        mcand   <= {{WIDTH{1'b0}}, a_mag};
                        mplier  <= b_mag;
                        sign    <= a_neg ^ b_neg;
                        acc     <= '0;
                        counter <= '0;
                    end
                end
                // mcand shifts one place per step, equivalent to multiplicand << counter.
                MUL_ITERATE: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand   <= mcand << 1;
                    mplier  <= mplier >> 1;
                    counter <= counter + CW'(1);
                end
                MUL_FINISH: begin
                    oResult   <= res;
                    oOverflow <= ovf;
                end
                MUL_DONE: begin
                    oOutputReady <= iInputReady;
                end
                default: begin
                    oOutputReady <= 1'b0;
                end
            endcase
        end
    end

endmodule
